// File: rtl/mips32_pkg.sv
`default_nettype none
// mips32_pkg -- opcodes, instruction classes, field positions and decode helpers
// shared by pipe_mips32_core and its hazard unit. Rev 1.0
package mips32_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } instr_type_e;

  // Anything not recognised behaves as HLT so a runaway fetch stops cleanly.
  function automatic instr_type_e decode_type(input logic [5:0] op);
    instr_type_e t;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
      OP_LW:                                         t = LOAD;
      OP_SW:                                         t = STORE;
      OP_BEQZ, OP_BNEQZ:                             t = BRANCH;
      default:                                       t = HALT;
    endcase
    return t;
  endfunction

  function automatic logic writes_reg(input instr_type_e t);
    return (t == RR_ALU) || (t == RM_ALU) || (t == LOAD);
  endfunction

  function automatic logic uses_rs(input instr_type_e t);
    return (t != HALT);
  endfunction

  function automatic logic uses_rt(input instr_type_e t);
    return (t == RR_ALU) || (t == STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_mips32_core_if.sv
`default_nettype none
// pipe_mips32_core_if -- instruction/data memory ports and debug register read
// between the core (master) and its memories/harness (slave). Rev 1.0
interface pipe_mips32_core_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we;
  logic [DW-1:0] dmem_rdata;
  logic [4:0]    dbg_raddr;
  logic [DW-1:0] dbg_rdata;

  modport master (
    output imem_addr, dmem_addr, dmem_wdata, dmem_we, dbg_rdata,
    input  imem_rdata, dmem_rdata, dbg_raddr
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we, dbg_rdata,
    output imem_rdata, dmem_rdata, dbg_raddr
  );
endinterface
`default_nettype wire

// File: rtl/mips32_hazard_unit.sv
`default_nettype none
// mips32_hazard_unit -- combinational interlock, flush and bypass-select logic
// for the five-stage pipe_mips32_core. Rev 1.0
module mips32_hazard_unit
  import mips32_pkg::*;
#(
  parameter int FORWARD = 1
) (
  input  logic        id_valid,
  input  instr_type_e id_type,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_valid,
  input  instr_type_e ex_type,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_dest,
  input  logic        mem_valid,
  input  instr_type_e mem_type,
  input  logic [4:0]  mem_dest,
  input  logic        wb_valid,
  input  instr_type_e wb_type,
  input  logic [4:0]  wb_dest,
  input  logic        branch_taken,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
);

  logic ex_wr, mem_wr, wb_wr, mem_fwd_ok;
  logic need_rs, need_rt, hit_ex, hit_mem;

  always_comb begin
    ex_wr      = ex_valid  && writes_reg(ex_type)  && (ex_dest  != 5'd0);
    mem_wr     = mem_valid && writes_reg(mem_type) && (mem_dest != 5'd0);
    wb_wr      = wb_valid  && writes_reg(wb_type)  && (wb_dest  != 5'd0);
    mem_fwd_ok = mem_wr && (mem_type != LOAD);

    need_rs = id_valid && uses_rs(id_type);
    need_rt = id_valid && uses_rt(id_type);
    hit_ex  = ex_wr  && ((need_rs && (id_rs == ex_dest))  || (need_rt && (id_rt == ex_dest)));
    hit_mem = mem_wr && ((need_rs && (id_rs == mem_dest)) || (need_rt && (id_rt == mem_dest)));

    // Without bypass a WB producer is still covered by register-file write-through.
    if (FORWARD != 0) stall = hit_ex && (ex_type == LOAD);
    else              stall = hit_ex || hit_mem;

    flush = branch_taken;

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FORWARD != 0) begin
      if (mem_fwd_ok && (mem_dest == ex_rs))  fwd_a = 2'b01;
      else if (wb_wr && (wb_dest == ex_rs))   fwd_a = 2'b10;
      if (mem_fwd_ok && (mem_dest == ex_rt))  fwd_b = 2'b01;
      else if (wb_wr && (wb_dest == ex_rt))   fwd_b = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_mips32_core.sv
`default_nettype none
// pipe_mips32_core -- single-clock five-stage MIPS32 pipeline with bypassing,
// load-use interlock, EX-resolved branches and sticky halt. Rev 1.0
module pipe_mips32_core
  import mips32_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 10,
  parameter int FORWARD = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_mips32_core_if.master  bus,
  output logic                retire,
  output logic                halted
);

  logic [AW-1:0] pc;
  logic          fetch_stop;
  logic          halt_r;
  logic [DW-1:0] regs [32];

  logic          ifid_valid;
  logic [DW-1:0] ifid_ir;
  logic [AW-1:0] ifid_npc;

  logic          idex_valid;
  instr_type_e   idex_type;
  logic [5:0]    idex_op;
  logic [4:0]    idex_rs, idex_rt, idex_dest;
  logic [DW-1:0] idex_a, idex_b, idex_imm;
  logic [AW-1:0] idex_npc;

  logic          exmem_valid;
  instr_type_e   exmem_type;
  logic [4:0]    exmem_dest;
  logic [DW-1:0] exmem_alu, exmem_b;

  logic          memwb_valid;
  instr_type_e   memwb_type;
  logic [4:0]    memwb_dest;
  logic [DW-1:0] memwb_alu, memwb_lmd;

  logic [5:0]    id_op;
  instr_type_e   id_type;
  logic [4:0]    id_rs, id_rt, id_rd, id_dest;
  logic [DW-1:0] id_imm, id_a, id_b;
  logic [DW-1:0] wb_val, op_a, op_b, alu;
  logic [AW-1:0] target;
  logic          wb_we, wb_halt, branch_taken, halt_issue;
  logic          stall, flush;
  logic [1:0]    fwd_a, fwd_b;

  // Decode and register read (WB write visible to ID in the same cycle).
  always_comb begin
    id_op   = ifid_ir[OP_HI:OP_LO];
    id_type = decode_type(id_op);
    id_rs   = ifid_ir[RS_HI:RS_LO];
    id_rt   = ifid_ir[RT_HI:RT_LO];
    id_rd   = ifid_ir[RD_HI:RD_LO];
    id_imm  = {{(DW-16){ifid_ir[IMM_HI]}}, ifid_ir[IMM_HI:IMM_LO]};
    case (id_type)
      RR_ALU:       id_dest = id_rd;
      RM_ALU, LOAD: id_dest = id_rt;
      default:      id_dest = 5'd0;
    endcase
    wb_val  = (memwb_type == LOAD) ? memwb_lmd : memwb_alu;
    wb_we   = memwb_valid && writes_reg(memwb_type) && (memwb_dest != 5'd0) && !halt_r;
    wb_halt = memwb_valid && (memwb_type == HALT);
    id_a    = (wb_we && (memwb_dest == id_rs)) ? wb_val : regs[id_rs];
    id_b    = (wb_we && (memwb_dest == id_rt)) ? wb_val : regs[id_rt];
  end

  always_comb begin
    case (fwd_a)
      2'b01:   op_a = exmem_alu;
      2'b10:   op_a = wb_val;
      default: op_a = idex_a;
    endcase
    case (fwd_b)
      2'b01:   op_b = exmem_alu;
      2'b10:   op_b = wb_val;
      default: op_b = idex_b;
    endcase
    case (idex_op)
      OP_ADD:       alu = op_a + op_b;
      OP_SUB:       alu = op_a - op_b;
      OP_AND:       alu = op_a & op_b;
      OP_OR:        alu = op_a | op_b;
      OP_SLT:       alu = DW'(op_a < op_b);
      OP_MUL:       alu = op_a * op_b;
      OP_ADDI:      alu = op_a + idex_imm;
      OP_SUBI:      alu = op_a - idex_imm;
      OP_SLTI:      alu = DW'(op_a < idex_imm);
      OP_LW, OP_SW: alu = op_a + idex_imm;
      default:      alu = '0;
    endcase
    target       = idex_npc + idex_imm[AW-1:0];
    branch_taken = idex_valid && (idex_type == BRANCH) &&
                   ((idex_op == OP_BEQZ) == (op_a == '0));
  end

  mips32_hazard_unit #(.FORWARD(FORWARD)) u_hazard (
    .id_valid     (ifid_valid),
    .id_type      (id_type),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_valid     (idex_valid),
    .ex_type      (idex_type),
    .ex_rs        (idex_rs),
    .ex_rt        (idex_rt),
    .ex_dest      (idex_dest),
    .mem_valid    (exmem_valid),
    .mem_type     (exmem_type),
    .mem_dest     (exmem_dest),
    .wb_valid     (memwb_valid),
    .wb_type      (memwb_type),
    .wb_dest      (memwb_dest),
    .branch_taken (branch_taken),
    .stall        (stall),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  assign halt_issue     = ifid_valid && (id_type == HALT) && !flush;
  assign halted         = halt_r || wb_halt;
  assign retire         = memwb_valid && !halt_r;
  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = exmem_alu[AW-1:0];
  assign bus.dmem_wdata = exmem_b;
  // Gated by rst_n so a store in MEM during a reset cycle never reaches the RAM.
  assign bus.dmem_we    = exmem_valid && (exmem_type == STORE) && !halted && rst_n;
  assign bus.dbg_rdata  = (bus.dbg_raddr == 5'd0) ? '0 : regs[bus.dbg_raddr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= '0;
      fetch_stop  <= 1'b0;
      halt_r      <= 1'b0;
      ifid_valid  <= 1'b0;
      ifid_ir     <= '0;
      ifid_npc    <= '0;
      idex_valid  <= 1'b0;
      idex_type   <= RR_ALU;
      idex_op     <= '0;
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_dest   <= '0;
      idex_a      <= '0;
      idex_b      <= '0;
      idex_imm    <= '0;
      idex_npc    <= '0;
      exmem_valid <= 1'b0;
      exmem_type  <= RR_ALU;
      exmem_dest  <= '0;
      exmem_alu   <= '0;
      exmem_b     <= '0;
      memwb_valid <= 1'b0;
      memwb_type  <= RR_ALU;
      memwb_dest  <= '0;
      memwb_alu   <= '0;
      memwb_lmd   <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (wb_halt) halt_r <= 1'b1;
      if (!halted) begin
        if (wb_we) regs[memwb_dest] <= wb_val;

        if (flush) begin
          pc         <= target;
          ifid_valid <= 1'b0;
        end else if (!stall) begin
          if (halt_issue || fetch_stop) begin
            ifid_valid <= 1'b0;
          end else begin
            pc         <= pc + AW'(1);
            ifid_valid <= 1'b1;
            ifid_ir    <= bus.imem_rdata;
            ifid_npc   <= pc + AW'(1);
          end
        end
        if (halt_issue) fetch_stop <= 1'b1;

        idex_valid <= ifid_valid && !flush && !stall;
        idex_type  <= id_type;
        idex_op    <= id_op;
        idex_rs    <= id_rs;
        idex_rt    <= id_rt;
        idex_dest  <= id_dest;
        idex_a     <= id_a;
        idex_b     <= id_b;
        idex_imm   <= id_imm;
        idex_npc   <= ifid_npc;

        exmem_valid <= idex_valid;
        exmem_type  <= idex_type;
        exmem_dest  <= idex_dest;
        exmem_alu   <= alu;
        exmem_b     <= op_b;

        memwb_valid <= exmem_valid;
        memwb_type  <= exmem_type;
        memwb_dest  <= exmem_dest;
        memwb_alu   <= exmem_alu;
        memwb_lmd   <= bus.dmem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_mips32_core.md
# pipe_mips32_core

Single-clock, parametrised successor to the two-phase MIPS32 pipeline. Five stages (IF, ID, EX, MEM, WB) with full data forwarding, load-use interlock, EX-resolved branches with flush, and clean halt. Instruction and data memories sit outside the core on combinational-read ports, so the same core serves the test harness and larger SoC builds.

## Interface
- `DW`, 32: datapath and register width; also the instruction width. Must be ≥ 32.
- `AW`, 10: word-address width of both memories.
- `FORWARD`, 1: 1 enables EX/MEM and MEM/WB bypass; 0 stalls on every RAW hazard.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_addr` out AW: fetch word address (= PC).
- `imem_rdata` in DW: instruction at `imem_addr`, same cycle.
- `dmem_addr` out AW: data word address (MEM stage).
- `dmem_wdata` out DW: store data.
- `dmem_we` out 1: store strobe, one cycle per SW.
- `dmem_rdata` in DW: load data at `dmem_addr`, same cycle.
- `dbg_raddr` in 5: debug register-file read index.
- `dbg_rdata` out DW: `Reg[dbg_raddr]`, combinational; 0 for index 0.
- `retire` out 1: pulses when a non-bubble instruction completes WB.
- `halted` out 1: sticky; set when HLT retires.

## Operation
- Opcodes, encoding and types are unchanged: ADD/SUB/AND/OR/SLT/MUL (rd = [15:11]); ADDI/SUBI/SLTI/LW (rt = [20:16]); SW; BEQZ/BNEQZ (test rs); HLT.
- Undefined opcodes are decoded as HLT.
- Immediate: sign-extend [15:0] to DW.
- Arithmetic is modulo 2^DW. SLT/SLTI compare unsigned and write 0 or 1. MUL keeps the low DW bits.
- Each stage register carries a valid bit; a bubble has valid=0 and no side effects.
- R0 is hardwired to zero: writes to it are dropped and it is never a forwarding source.
- Register file writes in WB. An ID read of the same register in that cycle returns the new value (write-through).
- Forwarding (FORWARD=1): EX operands take the youngest matching valid producer, EX/MEM first, then MEM/WB. An LW in EX/MEM is not a forwarding source.
- Load-use: if ID's rs/rt matches a valid LW in EX, PC and IF/ID hold and a bubble enters EX, costing one cycle.
- FORWARD=0: ID stalls while any valid writer in EX, MEM or WB targets rs/rt.
- Branch: target = NPC + Imm. Condition (rs==0 for BEQZ, rs≠0 for BNEQZ) is evaluated in EX on the forwarded operand.
- Taken branch: PC ← target; IF/ID and ID/EX are invalidated. Penalty is 2 cycles; no delay slot.
- Halt: a valid HLT in ID (and not flushed that cycle) freezes PC; IF/ID refills with bubbles.
- When HLT reaches WB, `halted` ← 1 and every stage register is frozen. `dmem_we` and register writes stay 0 until reset.
- Older instructions ahead of HLT complete normally.
- Priority when events coincide: reset > halt > taken-branch flush > load-use stall > normal advance. A flush overrides a simultaneous stall.

## Timing
- Reset values: PC=0; all valid bits 0; Reg[0..31]=0; `halted`=0; `retire`=0; `dmem_we`=0; `imem_addr`=0.
- Reset asserted mid-run takes effect at the next edge. Any store then in MEM is suppressed that cycle.
- The first instruction is fetched in the first cycle with `rst_n`=1 and retires 4 cycles later (`retire` high in cycle 5).
- Steady-state throughput is 1 instruction/cycle, minus stall and flush cycles.
- `dmem_we` is high in exactly the MEM cycle of a valid SW; data is written at that edge by the external RAM.
- PC wraps modulo 2^AW.

## Structure
- Package `mips32_pkg`: opcode constants, the type enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT), field-slice localparams, and a `decode_type` function.
- Sub-module `mips32_hazard_unit` (combinational): takes ID/EX/MEM/WB register indices, valids and types. Produces `stall`, `flush`, and the two-bit forward selects for A and B.
- The register file stays inline in the core.

## Test plan
- ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; HLT → R3=30, no stall cycles, `retire` high 4 consecutive cycles, `halted` at cycle 8.
- With FORWARD=0, same program → R3=30, 2 extra cycles before the ADD retires.
- dmem[5]=7; LW R4,5(R0); ADD R5,R4,R4 → exactly one bubble, R5=14.
- BEQZ R0,+2; ADDI R6,R0,1; ADDI R7,R0,1; ADDI R8,R0,3; HLT → R6=R7=0, R8=3, two-cycle gap in `retire`.
- ADDI R1,R0,9; SW R1,100(R0); HLT; ADDI R9,R0,5 → single `dmem_we` pulse at addr 100 with data 9, R9=0, `halted`=1, PC frozen.
- Reset pulsed on the cycle a SW is in MEM → no `dmem_we`; all outputs return to reset values; the program restarts from PC=0.
